// File: rtl/spi_xfer_arb_pkg.sv
// Shared types and defaults for the SPI transfer arbiter.
// The optional stall timeout is enabled with SPI_XFER_ARB_STALL_TIMEOUT_EN.
package spi_xfer_arb_pkg;

    // Transaction phases: grant, CS setup, byte launch, byte in flight, CS hold.
    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        START,
        BUSY,
        HOLD
    } state_t;

    localparam int DEF_NUM_REQ      = 4;
    localparam int DEF_CS_SETUP_CYC = 2;
    localparam int DEF_CS_HOLD_CYC  = 2;
    localparam int DEF_STALL_CYCLES = 255;

    // Width of a requester index; never narrower than one bit.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/spi_rr_pick.sv
// Combinational round-robin picker: returns the first requesting index at or
// after ptr, wrapping around, plus a flag saying whether anything is requesting.
module spi_rr_pick
    import spi_xfer_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    localparam int IW     = id_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      ptr,
    output logic [IW-1:0]      idx,
    output logic               any
);

    logic [IW-1:0] cand;

    // Scan offsets from farthest to nearest so the nearest requester wins.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path leaves it unassigned (no latch).
        idx  = '0;
        cand = '0;
        any  = |req;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            cand = IW'((int'(ptr) + i) % NUM_REQ);
            if (req[cand]) begin
                idx = cand;
            end
        end
    end

endmodule

// File: rtl/spi_xfer_arbiter.sv
// Shares one byte-wide SPI master between NUM_REQ requesters. Each granted
// transaction is a burst of bytes closed by the requester's last flag; grants
// rotate round-robin per transaction and each requester has its own chip select.
// Optional feature macro: SPI_XFER_ARB_STALL_TIMEOUT_EN (abort a transaction
// whose owner leaves START idle for STALL_CYCLES cycles).
module spi_xfer_arbiter
    import spi_xfer_arb_pkg::*;
#(
    parameter int NUM_REQ      = DEF_NUM_REQ,
    parameter int CS_SETUP_CYC = DEF_CS_SETUP_CYC,
    parameter int CS_HOLD_CYC  = DEF_CS_HOLD_CYC,
    parameter int STALL_CYCLES = DEF_STALL_CYCLES
) (
    input  logic                            clk_i,
    input  logic                            reset_i,
    input  logic [NUM_REQ-1:0]              req_valid_i,
    input  logic [NUM_REQ*8-1:0]            req_data_i,
    input  logic [NUM_REQ-1:0]              req_last_i,
    output logic [NUM_REQ-1:0]              req_ready_o,
    output logic                            rsp_valid_o,
    output logic [7:0]                      rsp_data_o,
    output logic [id_width(NUM_REQ)-1:0]    rsp_id_o,
    output logic                            rsp_last_o,
    output logic                            rsp_abort_o,
    output logic [7:0]                      spi_din_o,
    output logic                            spi_start_o,
    input  logic [7:0]                      spi_dout_i,
    input  logic                            spi_done_tick_i,
    input  logic                            spi_ready_i,
    output logic [NUM_REQ-1:0]              cs_n_o,
    output logic                            busy_o
);

    localparam int IW      = id_width(NUM_REQ);
    localparam int CNT_MAX = (CS_SETUP_CYC > CS_HOLD_CYC) ? CS_SETUP_CYC : CS_HOLD_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    if (NUM_REQ < 2 || NUM_REQ > 8 || CS_SETUP_CYC < 1 || CS_HOLD_CYC < 1 || STALL_CYCLES < 1) begin : g_bad_params
        $error("spi_xfer_arbiter: parameter out of range");
    end

    state_t           state;
    logic [IW-1:0]    grant;
    logic [IW-1:0]    rr_ptr;
    logic [IW-1:0]    pick_idx;
    logic             pick_any;
    logic             last;
    logic [CNT_W-1:0] cnt;
    logic [7:0]       grant_data;
    logic             handshake;

`ifdef SPI_XFER_ARB_STALL_TIMEOUT_EN
    localparam int SW = $clog2(STALL_CYCLES + 1);
    logic [SW-1:0]    stall_cnt;
    logic             abort_q;
    assign rsp_abort_o = abort_q;
`else
    assign rsp_abort_o = 1'b0;
`endif

    spi_rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .req (req_valid_i),
        .ptr (rr_ptr),
        .idx (pick_idx),
        .any (pick_any)
    );

    // Byte handshake with the granted requester; only it can ever see ready.
    always_comb begin
        grant_data         = req_data_i[8*grant +: 8];
        handshake          = (state == START) && spi_ready_i && req_valid_i[grant];
        req_ready_o        = '0;
        req_ready_o[grant] = handshake;
    end

    // Transaction FSM with all SPI, chip-select and response outputs registered.
    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments only, so every read sees the pre-edge value.
        if (reset_i) begin
            state       <= IDLE;
            grant       <= '0;
            rr_ptr      <= '0;
            last        <= 1'b0;
            cnt         <= '0;
            cs_n_o      <= '1;
            busy_o      <= 1'b0;
            spi_start_o <= 1'b0;
            spi_din_o   <= '0;
            rsp_valid_o <= 1'b0;
            rsp_data_o  <= '0;
            rsp_id_o    <= '0;
            rsp_last_o  <= 1'b0;
`ifdef SPI_XFER_ARB_STALL_TIMEOUT_EN
            stall_cnt   <= '0;
            abort_q     <= 1'b0;
`endif
        end else begin
            spi_start_o <= 1'b0;
            rsp_valid_o <= 1'b0;
`ifdef SPI_XFER_ARB_STALL_TIMEOUT_EN
            abort_q     <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        grant            <= pick_idx;
                        cs_n_o           <= '1;
                        cs_n_o[pick_idx] <= 1'b0;
                        busy_o           <= 1'b1;
                        cnt              <= '0;
`ifdef SPI_XFER_ARB_STALL_TIMEOUT_EN
                        stall_cnt        <= '0;
`endif
                        state            <= SETUP;
                    end
                end

                SETUP: begin
                    if (cnt == CNT_W'(CS_SETUP_CYC - 1)) begin
                        cnt   <= '0;
                        state <= START;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                START: begin
                    if (handshake) begin
                        spi_din_o   <= grant_data;
                        spi_start_o <= 1'b1;
                        last        <= req_last_i[grant];
`ifdef SPI_XFER_ARB_STALL_TIMEOUT_EN
                        stall_cnt   <= '0;
`endif
                        state       <= BUSY;
                    end
`ifdef SPI_XFER_ARB_STALL_TIMEOUT_EN
                    else if (!req_valid_i[grant]) begin
                        if (stall_cnt == SW'(STALL_CYCLES - 1)) begin
                            abort_q   <= 1'b1;
                            rsp_id_o  <= grant;
                            stall_cnt <= '0;
                            cnt       <= '0;
                            state     <= HOLD;
                        end else begin
                            stall_cnt <= stall_cnt + 1'b1;
                        end
                    end
`endif
                end

                BUSY: begin
                    if (spi_done_tick_i) begin
                        rsp_valid_o <= 1'b1;
                        rsp_data_o  <= spi_dout_i;
                        rsp_id_o    <= grant;
                        rsp_last_o  <= last;
                        if (last) begin
                            cnt   <= '0;
                            state <= HOLD;
                        end else begin
                            state <= START;
                        end
                    end
                end

                HOLD: begin
                    if (cnt == CNT_W'(CS_HOLD_CYC - 1)) begin
                        cs_n_o <= '1;
                        busy_o <= 1'b0;
                        rr_ptr <= (grant == IW'(NUM_REQ - 1)) ? '0 : grant + 1'b1;
                        state  <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_xfer_arbiter.sv
// Directed bench for spi_xfer_arbiter. The SPI master is played by tasks in
// the stimulus sequence. Define SPI_XFER_ARB_STALL_TIMEOUT_EN to add the stall case.
module tb_spi_xfer_arbiter;

    logic        clk = 1'b0;
    logic        reset_i;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_last;
    logic [3:0]  req_ready;
    logic        rsp_valid;
    logic [7:0]  rsp_data;
    logic [1:0]  rsp_id;
    logic        rsp_last;
    logic        rsp_abort;
    logic [7:0]  spi_din;
    logic        spi_start;
    logic [7:0]  spi_dout;
    logic        spi_done_tick;
    logic        spi_ready;
    logic [3:0]  cs_n;
    logic        busy;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    spi_xfer_arbiter #(
        .NUM_REQ      (4),
        .CS_SETUP_CYC (2),
        .CS_HOLD_CYC  (2),
        .STALL_CYCLES (8)
    ) dut (
        .clk_i           (clk),
        .reset_i         (reset_i),
        .req_valid_i     (req_valid),
        .req_data_i      (req_data),
        .req_last_i      (req_last),
        .req_ready_o     (req_ready),
        .rsp_valid_o     (rsp_valid),
        .rsp_data_o      (rsp_data),
        .rsp_id_o        (rsp_id),
        .rsp_last_o      (rsp_last),
        .rsp_abort_o     (rsp_abort),
        .spi_din_o       (spi_din),
        .spi_start_o     (spi_start),
        .spi_dout_i      (spi_dout),
        .spi_done_tick_i (spi_done_tick),
        .spi_ready_i     (spi_ready),
        .cs_n_o          (cs_n),
        .busy_o          (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    endtask

    // NOTE: inputs change and outputs are sampled 1 time unit after the rising edge, never on it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for a start pulse and check what was launched.
    task automatic wait_start(input string tag, input logic [7:0] exp_din, input logic [3:0] exp_cs);
        int n = 0;
        while (spi_start !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        check({tag, "_start_seen"}, 32'(spi_start), 32'h1);
        check({tag, "_din"}, 32'(spi_din), 32'(exp_din));
        check({tag, "_cs"}, 32'(cs_n), 32'(exp_cs));
    endtask

    // Play the SPI master for one byte: stay busy a cycle, then tick done.
    task automatic finish_byte(input string tag, input logic [7:0] reply, input logic [1:0] exp_id,
                               input logic exp_last, input logic [3:0] exp_cs);
        spi_ready = 1'b0;
        step();
        check({tag, "_start_one_cycle"}, 32'(spi_start), 32'h0);
        spi_dout      = reply;
        spi_done_tick = 1'b1;
        step();
        check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'h1);
        check({tag, "_rsp_data"}, 32'(rsp_data), 32'(reply));
        check({tag, "_rsp_id"}, 32'(rsp_id), 32'(exp_id));
        check({tag, "_rsp_last"}, 32'(rsp_last), 32'(exp_last));
        check({tag, "_rsp_cs"}, 32'(cs_n), 32'(exp_cs));
        spi_done_tick = 1'b0;
        spi_ready     = 1'b1;
        step();
        check({tag, "_rsp_pulse"}, 32'(rsp_valid), 32'h0);
    endtask

    // Wait (bounded) for the transaction to close and check CS release.
    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy !== 1'b0 && n < 40) begin
            step();
            n++;
        end
        check({tag, "_idle_busy"}, 32'(busy), 32'h0);
        check({tag, "_idle_cs"}, 32'(cs_n), 32'hF);
    endtask

    initial begin
        logic       bad;
        logic [3:0] cs_exp;
        int         order [5];

        reset_i       = 1'b1;
        req_valid     = '0;
        req_data      = '0;
        req_last      = '0;
        spi_dout      = '0;
        spi_done_tick = 1'b0;
        spi_ready     = 1'b1;

        // Reset values.
        step();
        step();
        reset_i = 1'b0;
        check("rst_cs", 32'(cs_n), 32'hF);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_start", 32'(spi_start), 32'h0);
        check("rst_din", 32'(spi_din), 32'h0);
        check("rst_ready", 32'(req_ready), 32'h0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        check("rst_rsp_data", 32'(rsp_data), 32'h0);
        check("rst_rsp_id", 32'(rsp_id), 32'h0);
        check("rst_abort", 32'(rsp_abort), 32'h0);

        // Single byte from requester 0, with exact timing.
        req_valid[0]    = 1'b1;
        req_data[7:0]   = 8'hA5;
        req_last[0]     = 1'b1;
        step();
        check("single_setup_cs", 32'(cs_n), 32'hE);
        check("single_setup_busy", 32'(busy), 32'h1);
        step();
        check("single_setup2_start", 32'(spi_start), 32'h0);
        step();
        check("single_start_ready", 32'(req_ready), 32'h1);
        check("single_start_nostart", 32'(spi_start), 32'h0);
        step();
        check("single_start_pulse", 32'(spi_start), 32'h1);
        check("single_din", 32'(spi_din), 32'hA5);
        check("single_ready_drop", 32'(req_ready), 32'h0);
        req_valid[0] = 1'b0;
        finish_byte("single", 8'h3C, 2'd0, 1'b1, 4'hE);
        check("single_hold_cs", 32'(cs_n), 32'hE);
        step();
        check("single_release_cs", 32'(cs_n), 32'hF);
        check("single_release_busy", 32'(busy), 32'h0);

        // Burst of three bytes from requester 2.
        req_valid[2]     = 1'b1;
        req_data[23:16]  = 8'h01;
        req_last[2]      = 1'b0;
        wait_start("burst_b0", 8'h01, 4'hB);
        req_data[23:16]  = 8'h02;
        finish_byte("burst_b0", 8'hB1, 2'd2, 1'b0, 4'hB);
        wait_start("burst_b1", 8'h02, 4'hB);
        req_data[23:16]  = 8'h03;
        req_last[2]      = 1'b1;
        finish_byte("burst_b1", 8'hB2, 2'd2, 1'b0, 4'hB);
        wait_start("burst_b2", 8'h03, 4'hB);
        req_valid[2]     = 1'b0;
        finish_byte("burst_b2", 8'hB3, 2'd2, 1'b1, 4'hB);
        wait_idle("burst");

        // Backpressure: SPI master not ready for 10 cycles in START.
        spi_ready        = 1'b0;
        req_valid[3]     = 1'b1;
        req_data[31:24]  = 8'h5A;
        req_last[3]      = 1'b1;
        step();
        step();
        step();
        bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (req_ready !== 4'h0 || spi_start !== 1'b0) bad = 1'b1;
            step();
        end
        check("bp_stalled", 32'(bad), 32'h0);
        check("bp_cs", 32'(cs_n), 32'h7);
        spi_ready = 1'b1;
        #1;
        check("bp_ready_rise", 32'(req_ready), 32'h8);
        step();
        check("bp_start", 32'(spi_start), 32'h1);
        check("bp_din", 32'(spi_din), 32'h5A);
        req_valid[3] = 1'b0;
        finish_byte("bp", 8'hC3, 2'd3, 1'b1, 4'h7);
        wait_idle("bp");

        // Reset while a byte is in flight.
        req_valid[1]     = 1'b1;
        req_data[15:8]   = 8'h77;
        req_last[1]      = 1'b1;
        wait_start("rstbusy", 8'h77, 4'hD);
        req_valid[1] = 1'b0;
        spi_ready    = 1'b0;
        step();
        reset_i = 1'b1;
        step();
        reset_i = 1'b0;
        check("rstbusy_cs", 32'(cs_n), 32'hF);
        check("rstbusy_busy", 32'(busy), 32'h0);
        check("rstbusy_rsp", 32'(rsp_valid), 32'h0);
        check("rstbusy_ready", 32'(req_ready), 32'h0);
        spi_dout      = 8'hEE;
        spi_done_tick = 1'b1;
        step();
        spi_done_tick = 1'b0;
        check("spurious_rsp", 32'(rsp_valid), 32'h0);
        check("spurious_data", 32'(rsp_data), 32'h0);
        check("spurious_cs", 32'(cs_n), 32'hF);
        spi_ready = 1'b1;

        // Fairness: everyone valid continuously; grants go 0,1,2,3,0.
        order     = '{0, 1, 2, 3, 0};
        req_data  = 32'h13121110;
        req_last  = 4'hF;
        req_valid = 4'hF;
        for (int t = 0; t < 5; t++) begin
            cs_exp            = 4'hF;
            cs_exp[order[t]]  = 1'b0;
            wait_start($sformatf("fair%0d", t), 8'(8'h10 + order[t]), cs_exp);
            if (t == 4) req_valid = '0;
            finish_byte($sformatf("fair%0d", t), 8'(8'h80 + order[t]), 2'(order[t]), 1'b1, cs_exp);
            wait_idle($sformatf("fair%0d", t));
        end

`ifdef SPI_XFER_ARB_STALL_TIMEOUT_EN
        // Requester 1 stalls after its first byte and is aborted.
        req_valid[1]     = 1'b1;
        req_data[15:8]   = 8'h31;
        req_last[1]      = 1'b0;
        wait_start("stall", 8'h31, 4'hD);
        req_valid[1] = 1'b0;
        finish_byte("stall", 8'h41, 2'd1, 1'b0, 4'hD);
        for (int i = 0; i < 6; i++) step();
        check("stall_early", 32'(rsp_abort), 32'h0);
        step();
        check("stall_abort", 32'(rsp_abort), 32'h1);
        check("stall_abort_id", 32'(rsp_id), 32'h1);
        check("stall_abort_norsp", 32'(rsp_valid), 32'h0);
        req_valid        = 4'h5;
        req_data[7:0]    = 8'h20;
        req_data[23:16]  = 8'h22;
        req_last         = 4'hF;
        step();
        check("stall_abort_pulse", 32'(rsp_abort), 32'h0);
        check("stall_hold_cs", 32'(cs_n), 32'hD);
        step();
        check("stall_release_cs", 32'(cs_n), 32'hF);
        step();
        check("stall_next_grant_cs", 32'(cs_n), 32'hB);
        wait_start("stall_next", 8'h22, 4'hB);
        req_valid = '0;
        finish_byte("stall_next", 8'h52, 2'd2, 1'b1, 4'hB);
        wait_idle("stall_next");
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
